// File: rtl/supersonic_ctrl_if.sv
// ---------------------------------------------------------------------------
// supersonic_ctrl_if
//   Handshake bundle between the main controller / ultrasonic sensor side
//   and the supersonic_ctrl sequencer.
//
//   Signals:
//     trigger    controller -> ctrl  measurement request, rising edge = request
//     triggerSuc ctrl -> controller  one-cycle pulse, sensor trigger pulse done
//     trig_out   ctrl -> sensor      trigger pin
//     echo       sensor -> ctrl      echo pin (asynchronous to clk)
//     valid      ctrl -> controller  one-cycle pulse, distance updated
//     distance   ctrl -> controller  distance in mm, all-ones = out of range
//     timeout    ctrl -> controller  one-cycle pulse with valid on timeout
//     busy       ctrl -> controller  sequencer not idle
//
//   Modports:
//     master  controller + sensor side (drives trigger and echo)
//     slave   the sequencer
// ---------------------------------------------------------------------------
interface supersonic_ctrl_if #(
  parameter int unsigned DIST_W = 32
);
  logic              trigger;
  logic              triggerSuc;
  logic              trig_out;
  logic              echo;
  logic              valid;
  logic [DIST_W-1:0] distance;
  logic              timeout;
  logic              busy;

  modport master (
    output trigger,
    output echo,
    input  triggerSuc,
    input  trig_out,
    input  valid,
    input  distance,
    input  timeout,
    input  busy
  );

  modport slave (
    input  trigger,
    input  echo,
    output triggerSuc,
    output trig_out,
    output valid,
    output distance,
    output timeout,
    output busy
  );
endinterface

// File: rtl/supersonic_ctrl.sv
// ---------------------------------------------------------------------------
// supersonic_ctrl
//   Ultrasonic range sensor sequencer. A rising edge on trigger starts a
//   fixed-width pulse on trig_out, then the echo pulse width is timed and
//   converted to millimetres. Timeouts on the echo wait and on the echo
//   measurement report all-ones with a timeout pulse. A hold-off interval
//   after each result keeps the sensor from being re-triggered too soon;
//   requests arriving meanwhile are remembered in a 1-deep pending flag.
//
//   Ports:
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   supersonic_ctrl_if.slave (trigger, triggerSuc, trig_out, echo,
//           valid, distance, timeout, busy)
//
//   Optional feature (macro SUPERSONIC_AVG4_EN):
//     When defined, one request runs four sensor measurements separated by
//     hold-off and reports their average. triggerSuc pulses only after the
//     first trigger pulse; any timeout aborts the sequence at once.
// ---------------------------------------------------------------------------
module supersonic_ctrl #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned CYC_PER_UNIT   = 291,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned HOLDOFF_CYCLES = 3000000,
  parameter int unsigned DIST_W         = 32
) (
  input logic               clk,
  input logic               rst,
  supersonic_ctrl_if.slave  bus
);

  // One shared down-the-phase counter serves TRIG, WAIT_ECHO, MEASURE and
  // HOLDOFF, so it is sized for the longest of them.
  localparam int unsigned CNT_MAX0 = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > TRIG_CYCLES) ? CNT_MAX0 : TRIG_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned SUB_W    = $clog2(CYC_PER_UNIT + 1);

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [SUB_W-1:0]  sub_t;
  typedef logic [DIST_W-1:0] dist_t;

  localparam cnt_t  TRIG_LAST = cnt_t'(TRIG_CYCLES - 1);
  localparam cnt_t  SUC_AT    = cnt_t'(TRIG_CYCLES - 2);
  localparam cnt_t  TO_LAST   = cnt_t'(TIMEOUT_CYCLES - 1);
  localparam cnt_t  HO_LAST   = cnt_t'(HOLDOFF_CYCLES - 1);
  localparam sub_t  SUB_LAST  = sub_t'(CYC_PER_UNIT - 1);
  localparam dist_t DIST_SAT  = {{(DIST_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_ECHO,
    S_MEASURE,
    S_DONE,
    S_HOLDOFF
  } state_t;

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  sub_t       sub_q, sub_d;
  dist_t      dist_q, dist_d;
  dist_t      distance_q, distance_d;
  logic [2:0] echo_sh_q, echo_sh_d;
  logic       trig_prev_q, trig_prev_d;
  logic       trig_edge_q, trig_edge_d;
  logic       pending_q, pending_d;
  logic       trig_out_q, trig_out_d;
  logic       trig_suc_q, trig_suc_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;
  logic       busy_q, busy_d;

`ifdef SUPERSONIC_AVG4_EN
  logic [1:0]        smp_q, smp_d;
  logic [DIST_W+1:0] acc_q, acc_d;
  logic [DIST_W+1:0] acc_sum;
`endif

  // echo_sh_q[0] is the metastability flop, [1] the synchronized echo and
  // [2] its registered copy used for edge detection.
  logic  echo_rise, echo_fall;
  dist_t dist_inc;

  assign echo_rise = echo_sh_q[1] & ~echo_sh_q[2];
  assign echo_fall = ~echo_sh_q[1] & echo_sh_q[2];

  // Distance including the current MEASURE cycle, so the falling-edge cycle
  // is counted and an echo of N*CYC_PER_UNIT cycles reads exactly N.
  assign dist_inc = (sub_q == SUB_LAST && dist_q != DIST_SAT) ? dist_q + 1'b1 : dist_q;

`ifdef SUPERSONIC_AVG4_EN
  assign acc_sum = acc_q + {2'b00, dist_inc};
`endif

  always_comb begin
    // NOTE: every _d is given a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    echo_sh_d   = {echo_sh_q[1:0], bus.echo};
    trig_prev_d = bus.trigger;
    trig_edge_d = bus.trigger & ~trig_prev_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    sub_d       = sub_q;
    dist_d      = dist_q;
    distance_d  = distance_q;
    pending_d   = pending_q;
    trig_out_d  = trig_out_q;
    trig_suc_d  = 1'b0;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;
`ifdef SUPERSONIC_AVG4_EN
    smp_d       = smp_q;
    acc_d       = acc_q;
`endif

    // Requests outside IDLE are remembered once; further edges are dropped.
    if (trig_edge_q && state_q != S_IDLE) pending_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (trig_edge_q || pending_q) begin
          pending_d  = 1'b0;
          state_d    = S_TRIG;
          cnt_d      = '0;
          trig_out_d = 1'b1;
          trig_suc_d = (TRIG_CYCLES == 1);
`ifdef SUPERSONIC_AVG4_EN
          smp_d      = '0;
          acc_d      = '0;
`endif
        end
      end

      S_TRIG: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TRIG_LAST) begin
          state_d    = S_WAIT_ECHO;
          cnt_d      = '0;
          trig_out_d = 1'b0;
        end else if (cnt_q == SUC_AT) begin
          // Raised one cycle early so the registered pulse lands on the
          // last trigger cycle.
`ifdef SUPERSONIC_AVG4_EN
          trig_suc_d = (smp_q == 2'd0);
`else
          trig_suc_d = 1'b1;
`endif
        end
      end

      S_WAIT_ECHO: begin
        if (echo_rise) begin
          state_d = S_MEASURE;
          cnt_d   = '0;
          sub_d   = '0;
          dist_d  = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d    = S_DONE;
          valid_d    = 1'b1;
          timeout_d  = 1'b1;
          distance_d = '1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_MEASURE: begin
        sub_d  = (sub_q == SUB_LAST) ? '0 : sub_q + 1'b1;
        dist_d = dist_inc;
        cnt_d  = cnt_q + 1'b1;
        if (echo_fall) begin
`ifdef SUPERSONIC_AVG4_EN
          if (smp_q == 2'd3) begin
            state_d    = S_DONE;
            valid_d    = 1'b1;
            distance_d = acc_sum[DIST_W+1:2];
          end else begin
            acc_d   = acc_sum;
            smp_d   = smp_q + 1'b1;
            state_d = S_HOLDOFF;
            cnt_d   = '0;
          end
`else
          state_d    = S_DONE;
          valid_d    = 1'b1;
          distance_d = dist_inc;
`endif
        end else if (cnt_q == TO_LAST) begin
          state_d    = S_DONE;
          valid_d    = 1'b1;
          timeout_d  = 1'b1;
          distance_d = '1;
        end
      end

      S_DONE: begin
        state_d = S_HOLDOFF;
        cnt_d   = '0;
`ifdef SUPERSONIC_AVG4_EN
        smp_d   = '0;
        acc_d   = '0;
`endif
      end

      S_HOLDOFF: begin
        if (cnt_q == HO_LAST) begin
`ifdef SUPERSONIC_AVG4_EN
          // Mid-sequence hold-off goes straight to the next sample.
          if (smp_q != 2'd0) begin
            state_d    = S_TRIG;
            cnt_d      = '0;
            trig_out_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sub_q       <= '0;
      dist_q      <= '0;
      distance_q  <= '0;
      echo_sh_q   <= '0;
      trig_prev_q <= 1'b0;
      trig_edge_q <= 1'b0;
      pending_q   <= 1'b0;
      trig_out_q  <= 1'b0;
      trig_suc_q  <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SUPERSONIC_AVG4_EN
      smp_q       <= '0;
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      dist_q      <= dist_d;
      distance_q  <= distance_d;
      echo_sh_q   <= echo_sh_d;
      trig_prev_q <= trig_prev_d;
      trig_edge_q <= trig_edge_d;
      pending_q   <= pending_d;
      trig_out_q  <= trig_out_d;
      trig_suc_q  <= trig_suc_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
`ifdef SUPERSONIC_AVG4_EN
      smp_q       <= smp_d;
      acc_q       <= acc_d;
`endif
    end
  end

  assign bus.trig_out   = trig_out_q;
  assign bus.triggerSuc = trig_suc_q;
  assign bus.valid      = valid_q;
  assign bus.distance   = distance_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_supersonic_ctrl.sv
// ---------------------------------------------------------------------------
// tb_supersonic_ctrl
//   Self-checking bench for supersonic_ctrl with small timing parameters.
//   Expected distances come from echo width / CYC_PER_UNIT (averaged over
//   four samples when SUPERSONIC_AVG4_EN is defined); timing expectations
//   come from the trigger width, timeout and hold-off intervals.
// ---------------------------------------------------------------------------
module tb_supersonic_ctrl;
  localparam int TRIG_CYCLES  = 5;
  localparam int CYC_PER_UNIT = 4;
  localparam int TIMEOUT      = 200;
  localparam int HOLDOFF      = 20;
  localparam int LIMIT        = 1000;
`ifdef SUPERSONIC_AVG4_EN
  localparam int NSAMP = 4;
`else
  localparam int NSAMP = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  supersonic_ctrl_if #(.DIST_W(32)) bus ();

  supersonic_ctrl #(
    .TRIG_CYCLES    (TRIG_CYCLES),
    .CYC_PER_UNIT   (CYC_PER_UNIT),
    .TIMEOUT_CYCLES (TIMEOUT),
    .HOLDOFF_CYCLES (HOLDOFF),
    .DIST_W         (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int run = 0, last_run = 0, suc_run = 0;
  int rise_cnt = 0, fall_cnt = 0, suc_cnt = 0, val_cnt = 0;
  int rise_cyc = 0, suc_cyc = 0;
  int overlap = 0, bad_tmo = 0, hold_err = 0;
  logic        trig_prev = 1'b0;
  logic [31:0] dist_prev = '0;
  logic [31:0] val_dist[$];
  bit          val_tmo[$];
  int          val_cyc[$];

  always @(negedge clk) begin
    if (rst) begin
      run       = 0;
      trig_prev = 1'b0;
      dist_prev = bus.distance;
    end else begin
      if (bus.trig_out) run++;
      if (bus.trig_out && !trig_prev) begin rise_cyc = cyc; rise_cnt++; end
      if (!bus.trig_out && trig_prev) begin last_run = run; run = 0; fall_cnt++; end
      if (bus.triggerSuc) begin suc_cnt++; suc_cyc = cyc; suc_run = run; end
      if (bus.valid) begin
        val_dist.push_back(bus.distance);
        val_tmo.push_back(bus.timeout);
        val_cyc.push_back(cyc);
        val_cnt++;
      end
      if (bus.valid && bus.triggerSuc) overlap++;
      if (bus.timeout && !bus.valid) bad_tmo++;
      if (!bus.valid && bus.distance !== dist_prev) hold_err++;
      trig_prev = bus.trig_out;
      dist_prev = bus.distance;
    end
  end

  // ---------------- stimulus helpers ----------------
  int last_c0 = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_trigger(output int c0);
    bus.trigger = 1'b1;
    c0 = cyc;
    tick(3);
    bus.trigger = 1'b0;
  endtask

  task automatic wait_fall(input int target);
    int n = 0;
    while (fall_cnt < target && n < LIMIT) begin tick(1); n++; end
    check("trig_pulse_count", fall_cnt, target);
  endtask

  task automatic wait_valid(input int target);
    int n = 0;
    while (val_cnt < target && n < LIMIT) begin tick(1); n++; end
    check("valid_count", val_cnt, target);
  endtask

  task automatic check_result(input int idx, input logic [31:0] exp_d, input bit exp_t);
    if (val_cnt > idx) begin
      check("distance", val_dist[idx], exp_d);
      check("timeout_flag", val_tmo[idx], exp_t);
    end
  endtask

  // One request: w[i] < 0 means no echo, w[i] > TIMEOUT times out in MEASURE.
  task automatic run_request(input int w[4], input int d[4]);
    int f0, v0, s0, sum;
    bit tmo;
    logic [31:0] exp_d;
    f0 = fall_cnt; v0 = val_cnt; s0 = suc_cnt; sum = 0; tmo = 1'b0;
    pulse_trigger(last_c0);
    for (int i = 0; i < NSAMP; i++) begin
      wait_fall(f0 + i + 1);
      tick(d[i]);
      if (w[i] < 0) begin tmo = 1'b1; break; end
      bus.echo = 1'b1;
      tick(w[i]);
      bus.echo = 1'b0;
      if (w[i] > TIMEOUT) begin tmo = 1'b1; break; end
      sum += w[i] / CYC_PER_UNIT;
    end
    wait_valid(v0 + 1);
    exp_d = tmo ? 32'hFFFF_FFFF : 32'(sum / NSAMP);
    check_result(v0, exp_d, tmo);
    check("trigger_suc_pulses", suc_cnt - s0, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w[4], d[4], c0, v0, f0, r0;
    rst = 1'b1;
    bus.trigger = 1'b0;
    bus.echo = 1'b0;

    // ---- reset state ----
    tick(1);
    check("rst_busy", bus.busy, 0);
    check("rst_trig_out", bus.trig_out, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_distance", bus.distance, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_trig_out", bus.trig_out, 0);
    check("post_rst_suc", bus.triggerSuc, 0);
    check("post_rst_timeout", bus.timeout, 0);
    check("post_rst_distance", bus.distance, 0);

`ifdef SUPERSONIC_AVG4_EN
    // ---- four-sample average ----
    run_request('{40, 44, 40, 36}, '{10, 5, 7, 3});
    // ---- missing echo on sample 3 aborts ----
    run_request('{40, 44, -1, 40}, '{4, 4, 4, 4});
`else
    // ---- basic measurement with trigger timing ----
    run_request('{40, 0, 0, 0}, '{10, 0, 0, 0});
    check("trig_latency", rise_cyc - last_c0, 2);
    check("trig_width", last_run, TRIG_CYCLES);
    check("suc_on_last_trig_cycle", suc_run, TRIG_CYCLES);

    // ---- echo never rises ----
    v0 = val_cnt;
    run_request('{-1, 0, 0, 0}, '{0, 0, 0, 0});
    if (val_cnt > v0) check("wait_timeout_latency", val_cyc[v0] - suc_cyc, TIMEOUT + 1);

    // ---- echo stuck high: MEASURE timeout, then held echo is ignored ----
    v0 = val_cnt; f0 = fall_cnt;
    pulse_trigger(c0);
    wait_fall(f0 + 1);
    tick(5);
    bus.echo = 1'b1;
    tick(250);
    wait_valid(v0 + 1);
    check_result(v0, 32'hFFFF_FFFF, 1'b1);
    v0 = val_cnt; f0 = fall_cnt;
    pulse_trigger(c0);
    wait_fall(f0 + 1);
    tick(30);
    check("held_echo_ignored", val_cnt, v0);
    check("held_echo_busy", bus.busy, 1);
    bus.echo = 1'b0;
    tick(5);
    bus.echo = 1'b1;
    tick(20);
    bus.echo = 1'b0;
    wait_valid(v0 + 1);
    check_result(v0, 32'd5, 1'b0);

    // ---- pending request: one extra measurement only ----
    v0 = val_cnt; f0 = fall_cnt; r0 = rise_cnt;
    pulse_trigger(c0);
    wait_fall(f0 + 1);
    tick(4);
    bus.echo = 1'b1;
    tick(10);
    pulse_trigger(c0);
    tick(27);
    bus.echo = 1'b0;
    wait_valid(v0 + 1);
    check_result(v0, 32'd10, 1'b0);
    tick(3);
    pulse_trigger(c0);
    wait_fall(f0 + 2);
    if (val_cnt > v0) check("pending_retrigger_delay", rise_cyc - val_cyc[v0], HOLDOFF + 2);
    tick(2);
    bus.echo = 1'b1;
    tick(12);
    bus.echo = 1'b0;
    wait_valid(v0 + 2);
    check_result(v0 + 1, 32'd3, 1'b0);
    tick(150);
    check("pending_extra_triggers", rise_cnt - r0, 2);
    check("pending_extra_valids", val_cnt - v0, 2);
`endif

    // ---- echo-width boundaries ----
    run_request('{TIMEOUT, TIMEOUT, TIMEOUT, TIMEOUT}, '{2, 2, 2, 2});
    run_request('{TIMEOUT + 1, 0, 0, 0}, '{2, 2, 2, 2});
    run_request('{3, 3, 3, 3}, '{1, 1, 1, 1});

    // ---- randomized requests ----
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        w[j] = int'($urandom_range(1, 199));
        d[j] = int'($urandom_range(1, 40));
      end
      run_request(w, d);
    end
    tick(HOLDOFF + 5);

    // ---- reset mid-TRIG drops trig_out at once ----
    pulse_trigger(c0);
    check("pre_rst_trig_out", bus.trig_out, 1);
    rst = 1'b1;
    #1;
    check("async_rst_trig_out", bus.trig_out, 0);
    check("async_rst_busy", bus.busy, 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // ---- reset mid-MEASURE: no valid follows ----
    v0 = val_cnt; f0 = fall_cnt; r0 = rise_cnt;
    pulse_trigger(c0);
    wait_fall(f0 + 1);
    tick(3);
    bus.echo = 1'b1;
    tick(12);
    check("measure_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("measure_rst_trig_out", bus.trig_out, 0);
    check("measure_rst_busy", bus.busy, 0);
    check("measure_rst_valid", bus.valid, 0);
    tick(2);
    bus.echo = 1'b0;
    rst = 1'b0;
    tick(300);
    check("no_valid_after_rst", val_cnt, v0);
    check("no_retrigger_after_rst", rise_cnt - r0, 1);
    check("idle_after_rst", bus.busy, 0);

    // ---- protocol invariants over the whole run ----
    check("valid_suc_overlap", overlap, 0);
    check("timeout_without_valid", bad_tmo, 0);
    check("distance_hold", hold_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/supersonic_ctrl.md
Name: supersonic_ctrl

Overview:
Sequencer for the ultrasonic range sensor used by the slicing controller. It takes a measurement request from the main controller and drives the sensor's trigger pin with a fixed-width pulse. It then times the sensor's echo pulse and returns a distance with a one-cycle valid strobe. It also enforces sensor timeout and the minimum re-trigger interval, so the main controller only sees the trigger / triggerSuc / valid / distance handshake.

Parameters:
TRIG_CYCLES, 500, width of the sensor trigger pulse in clk cycles (10 us at 50 MHz).
CYC_PER_UNIT, 291, clk cycles of echo-high time per 1 mm of distance (round trip, 50 MHz).
TIMEOUT_CYCLES, 1500000, maximum cycles allowed in WAIT_ECHO and, separately, in MEASURE (30 ms).
HOLDOFF_CYCLES, 3000000, minimum idle time after a result before the next sensor trigger (60 ms).
DIST_W, 32, distance output width.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
trigger  in  1  measurement request from main controller; rising edge = request
triggerSuc  out  1  one-cycle pulse: sensor trigger pulse completed
trig_out  out  1  trigger pin to sensor
echo  in  1  echo pin from sensor, asynchronous
valid  out  1  one-cycle pulse: distance is updated
distance  out  DIST_W  measured distance in mm; all-ones = out of range
timeout  out  1  one-cycle pulse, coincident with valid, when the measurement timed out
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, distance 0, state IDLE, pending cleared, counters 0. Reset takes effect asynchronously. A reset mid-operation drops trig_out immediately and no valid is emitted.
- echo passes through a 2-flop synchronizer. Edge detection uses the synchronized value and its registered copy.
- A trigger rising edge is detected with a registered copy of trigger. Accepted in IDLE, or latched into a 1-deep pending flag otherwise. Further edges while pending is set are dropped.
- IDLE: on a trigger edge or pending=1, clear pending and go to TRIG next cycle.
- TRIG: trig_out=1 for exactly TRIG_CYCLES cycles. On the last cycle triggerSuc=1 for one cycle. Then go to WAIT_ECHO.
- WAIT_ECHO: wait for a synchronized echo rising edge. An echo already high on entry is ignored until it falls and rises again. On the edge: clear counters and go to MEASURE. After TIMEOUT_CYCLES cycles without an edge: go to DONE with the timeout flag set.
- MEASURE: sub-counter counts 0..CYC_PER_UNIT-1. On wrap, dist_cnt increments, saturating at 2^DIST_W-2. On a synchronized echo falling edge, go to DONE. If TIMEOUT_CYCLES elapse in MEASURE, go to DONE with timeout set.
- DONE (1 cycle): valid=1. distance <= dist_cnt, or all-ones on timeout, in which case timeout=1. Go to HOLDOFF.
- HOLDOFF: count HOLDOFF_CYCLES, then go to IDLE. A trigger edge seen here sets pending and is serviced from IDLE, so the next TRIG starts HOLDOFF_CYCLES+2 cycles after valid.
- distance holds its value between valid pulses. valid and triggerSuc are never asserted in the same cycle.
- Latency from trigger edge to trig_out=1: 2 cycles (edge register, then IDLE→TRIG).

Optional Feature:
Macro SUPERSONIC_AVG4_EN.
- Defined: one request performs 4 sensor measurements, each TRIG → WAIT_ECHO → MEASURE, separated by HOLDOFF.
- triggerSuc pulses only after the first trig pulse. valid pulses once, after the 4th measurement.
- distance = (sum of 4 dist_cnt) >> 2. The accumulator is DIST_W+2 bits.
- A timeout in any sample aborts the sequence immediately to DONE with all-ones and timeout=1.
- Not defined: single measurement per request as described above.

Test Plan:
Sim parameters for all scenarios: TRIG_CYCLES=5, CYC_PER_UNIT=4, TIMEOUT_CYCLES=200, HOLDOFF_CYCLES=20, DIST_W=32.
1. Reset held 3 cycles, then released -> all outputs 0, busy=0. Reasserted mid-MEASURE -> trig_out=0, busy=0 immediately, no valid follows.
2. trigger rise, echo high 40 cycles starting 10 cycles after triggerSuc -> trig_out high exactly 5 cycles; triggerSuc on its last cycle; valid with distance=10, timeout=0.
3. trigger rise, echo never rises -> valid and timeout together 200 cycles after entering WAIT_ECHO, distance=32'hFFFFFFFF.
4. echo rises and stays high 250 cycles -> timeout after 200 MEASURE cycles, distance=all-ones. Next request with echo high at WAIT_ECHO entry is not measured until echo toggles low then high.
5. Second trigger edge during MEASURE, third during HOLDOFF -> exactly one extra measurement; its trig_out rises 22 cycles after the first valid.
6. SUPERSONIC_AVG4_EN defined, echo widths 40, 44, 40, 36 -> one triggerSuc, one valid, distance=10. Echo missing on sample 3 -> timeout, distance=all-ones.
